itpmem_st2_untrunc: RTL

Inverse-direction stage-2 transpose memory. It accepts the 16 column vectors that the stage-2 truncating transpose emits, one per beat, and re-transposes them into 16 row vectors in the original truncated-row format. Rows 12..15 carry 12 valid elements in the upper slices and zeros in the low 4 slices. The block sits on the inverse 2-D transform path. It is double-buffered (ping-pong), so a new block can stream in while the previous one drains.

---
 rtl/tpmem_pkg.sv | 14 +
 rtl/itpmem_bank.sv | 73 +++++++
 rtl/itpmem_st2_untrunc.sv | 97 +++++++++
 3 files changed

// File: rtl/tpmem_pkg.sv
// Shared constants and element-slice helper for the stage-2 transpose memories
// (forward truncating and inverse untruncating directions).
package tpmem_pkg;

    localparam int N_DIM   = 16;
    localparam int N_FULL  = 12;
    localparam int N_TRUNC = 4;

    // Element e of a packed vector lives at [elem_lo(e)+BW-1 : elem_lo(e)]; element 0 is in the MSBs.
    function automatic int elem_lo(input int e, input int bw);
        return (N_DIM - 1 - e) * bw;
    endfunction

endpackage

// File: rtl/itpmem_bank.sv
// One ping/pong bank: 12 full columns plus 4 columns holding only elements 0..11.
// Column-wide write port, combinational row read with zero padding for rows 12..15.
module itpmem_bank
    import tpmem_pkg::*;
#(
    parameter int BW = 12
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_we,
    input  logic [3:0]          i_wcol,
    input  logic [N_DIM*BW-1:0] i_wdata,
    input  logic [3:0]          i_rrow,
    output logic [N_DIM*BW-1:0] o_rrow_data
);

    logic [BW-1:0] full_q  [N_FULL][N_DIM];
    logic [BW-1:0] full_d  [N_FULL][N_DIM];
    logic [BW-1:0] trunc_q [N_TRUNC][N_FULL];
    logic [BW-1:0] trunc_d [N_TRUNC][N_FULL];

    always_comb begin
        full_d  = full_q;
        trunc_d = trunc_q;
        if (i_we) begin
            for (int c = 0; c < N_FULL; c++) begin
                if (i_wcol == 4'(c)) begin
                    for (int e = 0; e < N_DIM; e++) begin
                        full_d[c][e] = i_wdata[elem_lo(e, BW) +: BW];
                    end
                end
            end
            // Truncated columns drop elements 12..15 on the way in.
            for (int t = 0; t < N_TRUNC; t++) begin
                if (i_wcol == 4'(N_FULL + t)) begin
                    for (int e = 0; e < N_FULL; e++) begin
                        trunc_d[t][e] = i_wdata[elem_lo(e, BW) +: BW];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full_q  <= '{default: '0};
            trunc_q <= '{default: '0};
        end else begin
            full_q  <= full_d;
            trunc_q <= trunc_d;
        end
    end

    always_comb begin
        o_rrow_data = '0;
        for (int c = 0; c < N_FULL; c++) begin
            for (int r = 0; r < N_DIM; r++) begin
                if (i_rrow == 4'(r)) begin
                    o_rrow_data[elem_lo(c, BW) +: BW] = full_q[c][r];
                end
            end
        end
        // Rows 12..15 have no source in the truncated columns and stay zero.
        for (int t = 0; t < N_TRUNC; t++) begin
            for (int r = 0; r < N_FULL; r++) begin
                if (i_rrow == 4'(r)) begin
                    o_rrow_data[elem_lo(N_FULL + t, BW) +: BW] = trunc_q[t][r];
                end
            end
        end
    end

endmodule

// File: rtl/itpmem_st2_untrunc.sv
// Inverse stage-2 transpose memory: 16 column beats in, 16 row vectors out,
// ping-pong banked so a new block fills while the previous one drains.
module itpmem_st2_untrunc
    import tpmem_pkg::*;
#(
    parameter int BW = 12
) (
    input  logic                i_clk,
    input  logic                i_Reset,
    input  logic [N_DIM*BW-1:0] i_data,
    input  logic                i_enable,
    output logic [N_DIM*BW-1:0] o_data,
    output logic                o_en,
    output logic [3:0]          o_row
);

    logic [3:0]          wcnt_q, wcnt_d;
    logic                wsel_q, wsel_d;
    logic                drain_q, drain_d;
    logic [3:0]          rcnt_q, rcnt_d;
    logic [N_DIM*BW-1:0] o_data_q, o_data_d;
    logic                o_en_q, o_en_d;
    logic [3:0]          o_row_q, o_row_d;

    logic                swap;
    logic [N_DIM*BW-1:0] row_b0, row_b1, rd_row;

    assign swap = i_enable && (wcnt_q == 4'd15);

    itpmem_bank #(.BW(BW)) u_bank0 (
        .i_clk       (i_clk),
        .i_rst_n     (i_Reset),
        .i_we        (i_enable && !wsel_q),
        .i_wcol      (wcnt_q),
        .i_wdata     (i_data),
        .i_rrow      (rcnt_q),
        .o_rrow_data (row_b0)
    );

    itpmem_bank #(.BW(BW)) u_bank1 (
        .i_clk       (i_clk),
        .i_rst_n     (i_Reset),
        .i_we        (i_enable && wsel_q),
        .i_wcol      (wcnt_q),
        .i_wdata     (i_data),
        .i_rrow      (rcnt_q),
        .o_rrow_data (row_b1)
    );

    // The read bank is always the one not currently being written.
    assign rd_row = wsel_q ? row_b0 : row_b1;

    always_comb begin
        wcnt_d  = i_enable ? wcnt_q + 4'd1 : wcnt_q;
        wsel_d  = wsel_q ^ swap;
        drain_d = drain_q;
        rcnt_d  = rcnt_q;
        // A swap on the final drain cycle restarts the drain without a gap.
        if (swap) begin
            drain_d = 1'b1;
            rcnt_d  = 4'd0;
        end else if (drain_q) begin
            rcnt_d = rcnt_q + 4'd1;
            if (rcnt_q == 4'd15) begin
                drain_d = 1'b0;
            end
        end
        o_data_d = drain_q ? rd_row : '0;
        o_en_d   = drain_q;
        o_row_d  = drain_q ? rcnt_q : 4'd0;
    end

    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            wcnt_q   <= 4'd0;
            wsel_q   <= 1'b0;
            drain_q  <= 1'b0;
            rcnt_q   <= 4'd0;
            o_data_q <= '0;
            o_en_q   <= 1'b0;
            o_row_q  <= 4'd0;
        end else begin
            wcnt_q   <= wcnt_d;
            wsel_q   <= wsel_d;
            drain_q  <= drain_d;
            rcnt_q   <= rcnt_d;
            o_data_q <= o_data_d;
            o_en_q   <= o_en_d;
            o_row_q  <= o_row_d;
        end
    end

    assign o_data = o_data_q;
    assign o_en   = o_en_q;
    assign o_row  = o_row_q;

endmodule
